// File: rtl/leb128_enc32.sv
// Streaming LEB128 encoder: one 32-bit word in, its 1..5 byte LEB128 sequence out.
// SIGNED selects ULEB128 (0) or SLEB128 (1) at elaboration time.
module leb128_enc32 #(
    parameter bit SIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sreg_q, sreg_d;
    logic [2:0]  idx_q, idx_d;

    logic [31:0] shr_log;
    logic [31:0] shr_ar;
    logic [31:0] shr;
    logic        last;
    logic        out_xfer;
    logic        in_xfer;

    // Kept as separate assigns so the arithmetic shift is not made unsigned by a mixed ?: context.
    assign shr_log = sreg_q >> 7;
    assign shr_ar  = $signed(sreg_q) >>> 7;
    assign shr     = SIGNED ? shr_ar : shr_log;

    always_comb begin
        last = 1'b0;
        if (idx_q == 3'd4) begin
            last = 1'b1;
        end else if (SIGNED) begin
            last = ((shr == 32'd0) && !sreg_q[6]) || ((shr == 32'hFFFF_FFFF) && sreg_q[6]);
        end else begin
            last = (shr == 32'd0);
        end
    end

    assign out_valid = (state_q == EMIT);
    // Gated with out_valid so the idle outputs read as zero after reset.
    assign out_last  = out_valid && last;
    assign out_data  = {out_valid && !last, sreg_q[6:0]};
    assign out_xfer  = out_valid && out_ready;
    assign in_ready  = (state_q == IDLE) || (out_xfer && last);
    assign in_xfer   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        if (in_xfer) begin
            state_d = EMIT;
            sreg_d  = in_data;
            idx_d   = 3'd0;
        end else if (out_xfer) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                sreg_d = shr;
                idx_d  = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= 32'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_leb128_enc32.sv
// Bench for leb128_enc32: an unsigned and a signed instance, scoreboard of expected bytes.
module tb_leb128_enc32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid_u = 1'b0, in_ready_u, out_valid_u, out_ready_u = 1'b1, out_last_u;
    logic [31:0] in_data_u = 32'd0;
    logic [7:0]  out_data_u;
    logic        in_valid_s = 1'b0, in_ready_s, out_valid_s, out_ready_s = 1'b1, out_last_s;
    logic [31:0] in_data_s = 32'd0;
    logic [7:0]  out_data_s;

    int checks = 0;
    int passed = 0;

    // {last, byte}
    logic [8:0] q_u[$];
    logic [8:0] q_s[$];

    always #5 clk = ~clk;

    leb128_enc32 #(.SIGNED(1'b0)) u_uns (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_u), .in_ready(in_ready_u), .in_data(in_data_u),
        .out_valid(out_valid_u), .out_ready(out_ready_u), .out_data(out_data_u), .out_last(out_last_u)
    );

    leb128_enc32 #(.SIGNED(1'b1)) u_sgn (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s), .out_last(out_last_s)
    );

    task automatic expect_bytes(input bit sgn, input int n, input logic [39:0] b);
        for (int i = 0; i < n; i++) begin
            if (sgn) q_s.push_back({(i == n - 1), b[8*i +: 8]});
            else     q_u.push_back({(i == n - 1), b[8*i +: 8]});
        end
    endtask

    // Reference LEB128 encoder used for the random values.
    task automatic model_push(input bit sgn, input logic [31:0] v);
        logic [31:0] x;
        logic [7:0]  b;
        bit          more;
        x = v;
        more = 1'b1;
        while (more) begin
            b = {1'b0, x[6:0]};
            if (sgn) begin
                x = $signed(x) >>> 7;
                more = !(((x == 32'd0) && !b[6]) || ((x == 32'hFFFF_FFFF) && b[6]));
            end else begin
                x = x >> 7;
                more = (x != 32'd0);
            end
            if (sgn) q_s.push_back({!more, more, b[6:0]});
            else     q_u.push_back({!more, more, b[6:0]});
        end
    endtask

    // Presents v until accepted; returns at posedge+1 of the accept edge.
    task automatic send(input bit sgn, input logic [31:0] v, input bit hold);
        bit ok;
        ok = 1'b0;
        if (sgn) begin in_valid_s = 1'b1; in_data_s = v; end
        else     begin in_valid_u = 1'b1; in_data_u = v; end
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = sgn ? in_ready_s : in_ready_u;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_accept sgn=%0d value=%h: in_ready never high, required 1", sgn, v);
        end
        if (!hold) begin
            if (sgn) begin in_valid_s = 1'b0; in_data_s = 32'hDEAD_BEEF; end
            else     begin in_valid_u = 1'b0; in_data_u = 32'hDEAD_BEEF; end
        end
    endtask

    task automatic wait_drain(input bit sgn);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk);
            #1;
            ok = sgn ? (q_s.size() == 0 && !out_valid_s) : (q_u.size() == 0 && !out_valid_u);
        end
        checks++;
        if (ok) passed++;
        else $display("FAIL drain sgn=%0d: pending=%0d, required 0 and out_valid 0",
                      sgn, sgn ? q_s.size() : q_u.size());
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_valid_u, out_data_u, out_last_u, in_ready_u} !== {1'b0, 8'h00, 1'b0, 1'b1})
            $display("FAIL reset_uns got v=%b d=%h l=%b r=%b, required v=0 d=00 l=0 r=1",
                     out_valid_u, out_data_u, out_last_u, in_ready_u);
        else passed++;
        checks++;
        if ({out_valid_s, out_data_s, out_last_s, in_ready_s} !== {1'b0, 8'h00, 1'b0, 1'b1})
            $display("FAIL reset_sgn got v=%b d=%h l=%b r=%b, required v=0 d=00 l=0 r=1",
                     out_valid_s, out_data_s, out_last_s, in_ready_s);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        expect_bytes(0, 1, 40'h00);                   send(0, 32'd0, 0);
        expect_bytes(0, 1, 40'h2A);                   send(0, 32'd42, 0);
        expect_bytes(0, 3, {8'h26, 8'h8E, 8'hE5});    send(0, 32'd624485, 0);
        expect_bytes(0, 5, {8'h0F, 32'hFFFF_FFFF});   send(0, 32'hFFFF_FFFF, 0);
        expect_bytes(0, 2, {8'h01, 8'h80});           send(0, 32'h80, 0);
        wait_drain(0);
    endtask

    task automatic test_signed();
        expect_bytes(1, 3, {8'h78, 8'hBB, 8'hC0});    send(1, -32'sd123456, 0);
        expect_bytes(1, 1, 40'h7F);                   send(1, 32'hFFFF_FFFF, 0);
        expect_bytes(1, 1, 40'h3F);                   send(1, 32'd63, 0);
        expect_bytes(1, 2, {8'h00, 8'hC0});           send(1, 32'd64, 0);
        expect_bytes(1, 5, {8'h78, 32'h8080_8080});   send(1, 32'h8000_0000, 0);
        wait_drain(1);
    endtask

    task automatic test_backpressure();
        bit         rdy [6] = '{1, 0, 0, 1, 0, 1};
        logic [7:0] ed  [6] = '{8'hE5, 8'h8E, 8'h8E, 8'h8E, 8'h26, 8'h26};
        bit         eir [6] = '{0, 0, 0, 0, 0, 1};
        expect_bytes(0, 3, {8'h26, 8'h8E, 8'hE5});
        send(0, 32'd624485, 0);
        for (int c = 0; c < 6; c++) begin
            out_ready_u = rdy[c];
            @(negedge clk);
            checks++;
            if ({out_valid_u, out_data_u, out_last_u, in_ready_u} !== {1'b1, ed[c], (ed[c] == 8'h26), eir[c]})
                $display("FAIL stall_c%0d got v=%b d=%h l=%b r=%b, required v=1 d=%h l=%b r=%b",
                         c, out_valid_u, out_data_u, out_last_u, in_ready_u, ed[c], (ed[c] == 8'h26), eir[c]);
            else passed++;
            @(posedge clk);
            #1;
        end
        out_ready_u = 1'b1;
        wait_drain(0);
    endtask

    task automatic test_back_to_back();
        expect_bytes(0, 1, 40'h2A);
        expect_bytes(0, 2, {8'h02, 8'hAC});
        send(0, 32'd42, 1);
        in_data_u = 32'd300;
        @(negedge clk);
        checks++;
        if ({out_valid_u, out_data_u, out_last_u, in_ready_u} !== {1'b1, 8'h2A, 1'b1, 1'b1})
            $display("FAIL b2b_first got v=%b d=%h l=%b r=%b, required v=1 d=2a l=1 r=1",
                     out_valid_u, out_data_u, out_last_u, in_ready_u);
        else passed++;
        @(posedge clk);
        #1;
        in_valid_u = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid_u, out_data_u, out_last_u} !== {1'b1, 8'hAC, 1'b0})
            $display("FAIL b2b_second got v=%b d=%h l=%b, required v=1 d=ac l=0",
                     out_valid_u, out_data_u, out_last_u);
        else passed++;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({out_valid_u, out_data_u, out_last_u} !== {1'b1, 8'h02, 1'b1})
            $display("FAIL b2b_third got v=%b d=%h l=%b, required v=1 d=02 l=1",
                     out_valid_u, out_data_u, out_last_u);
        else passed++;
        wait_drain(0);
    endtask

    task automatic test_mid_reset();
        bit ok;
        ok = 1'b0;
        expect_bytes(0, 2, {8'hFF, 8'hFF});
        q_u[1] = {1'b0, 8'hFF};
        send(0, 32'hFFFF_FFFF, 0);
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clk);
            #1;
            ok = (q_u.size() == 0);
        end
        reset = 1'b1;
        in_valid_u = 1'b1;
        in_data_u = 32'd99;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid_u = 1'b0;
        @(negedge clk);
        checks++;
        if (ok && out_valid_u === 1'b0 && in_ready_u === 1'b1) passed++;
        else $display("FAIL mid_reset got v=%b r=%b bytes_seen=%b, required v=0 r=1 bytes_seen=1",
                      out_valid_u, in_ready_u, ok);
        @(posedge clk);
        #1;
        expect_bytes(0, 1, 40'h05);
        send(0, 32'd5, 0);
        wait_drain(0);
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if (i[0]) v = ~v;
            model_push(0, v); send(0, v, 0);
            model_push(1, v); send(1, v, 0);
        end
        wait_drain(0);
        wait_drain(1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!reset && out_valid_u && out_ready_u) begin
                    checks++;
                    if (q_u.size() == 0)
                        $display("FAIL uns_byte unexpected d=%h l=%b, required no byte", out_data_u, out_last_u);
                    else if ({out_last_u, out_data_u} !== q_u[0])
                        $display("FAIL uns_byte got l=%b d=%h, required l=%b d=%h",
                                 out_last_u, out_data_u, q_u[0][8], q_u[0][7:0]);
                    else passed++;
                    if (q_u.size() != 0) void'(q_u.pop_front());
                end
            end
            forever begin
                @(negedge clk);
                if (!reset && out_valid_s && out_ready_s) begin
                    checks++;
                    if (q_s.size() == 0)
                        $display("FAIL sgn_byte unexpected d=%h l=%b, required no byte", out_data_s, out_last_s);
                    else if ({out_last_s, out_data_s} !== q_s[0])
                        $display("FAIL sgn_byte got l=%b d=%h, required l=%b d=%h",
                                 out_last_s, out_data_s, q_s[0][8], q_s[0][7:0]);
                    else passed++;
                    if (q_s.size() != 0) void'(q_s.pop_front());
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
